fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side drain engine for the team's FIFOs: runs in the FIFO read-clock domain, issues `fifo_rd_en`, absorbs the FIFO's one-cycle registered read latency, and presents the words as a valid/ready stream. A 3-entry internal buffer with credit-based issue gives full throughput (one word per cycle) with no combinational path from `m_ready` to `fifo_rd_en`. It sits between `fifo_async`/`fifo_sync` read ports and any downstream consumer.

## Interface
- `DATA_WIDTH`, 8, width of FIFO words and stream data.
- `CNT_WIDTH`, 16, width of the delivered-word counter.

- `clk`  in  1  read-side clock (same clock as the FIFO read port).
- `reset`  in  1  synchronous, active-high reset; must also reset the attached FIFO's read side.
- `enable`  in  1  1 = allowed to issue new FIFO reads.
- `fifo_empty`  in  1  FIFO empty flag, same cycle as `fifo_rd_en`.
- `fifo_dout`  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `m_valid`  out  1  stream word available.
- `m_ready`  in  1  consumer accepts the word when `m_valid && m_ready`.
- `m_data`  out  DATA_WIDTH  stream word (buffer head).
- `rd_count`  out  CNT_WIDTH  number of words delivered downstream, wraps modulo 2^CNT_WIDTH.

## Operation
- State: 3-entry circular buffer (`wptr`, `rptr` 2-bit, wrap 2→0), occupancy `occ` 0..3, in-flight flag `inflight` 0/1.
- Issue: `fifo_rd_en = enable && !fifo_empty && (occ + inflight < 3) && !reset`. Depends only on registered state, `enable`, `fifo_empty`.
- Accepted read (`fifo_rd_en` high) sets `inflight` for the next cycle; otherwise `inflight` clears.
- Capture: when `inflight` is high, `fifo_dout` is written to `buf[wptr]` at the end of that cycle, `wptr` advances.
- Pop: `m_valid && m_ready` advances `rptr`, increments `rd_count`.
- `occ` next = `occ` + capture − pop; simultaneous capture and pop leave `occ` unchanged. The credit rule guarantees capture never happens with `occ = 3`.
- `m_valid = (occ != 0)`, `m_data = buf[rptr]`. `m_data` holds stable while `m_valid && !m_ready`.
- `enable` low: no new reads; an in-flight word is still captured; buffered words still drain.
- `fifo_empty` high: no read issued that cycle. No read is ever issued on an empty FIFO.
- Reset: `occ`, `inflight`, `wptr`, `rptr`, `rd_count` clear. Any in-flight or buffered words are discarded. This is acceptable only because the FIFO read side resets together with this block.

## Timing
- Reset values: `fifo_rd_en = 0` (also forced 0 during reset cycles), `m_valid = 0`, `m_data = 0` (buffer cleared), `rd_count = 0`.
- Latency: `fifo_rd_en` high in cycle n → `fifo_dout` valid in n+1 → captured at end of n+1 → `m_valid` high with that word in n+2.
- Throughput: with `m_ready` held high and FIFO non-empty, `fifo_rd_en` stays high every cycle (steady state `occ = 1`, `inflight = 1`) and `m_valid` stays high every cycle.
- Backpressure: with `m_ready` low from start, exactly 3 reads are issued, then `fifo_rd_en` stays low until a pop frees a credit. After a pop in cycle k, the next read is issued in k+1.
- Order: stream order equals FIFO read order, with no loss or duplication, across pointer wrap.

## Test plan
- Reset held 3 cycles with `enable = 1`, FIFO non-empty → `fifo_rd_en`, `m_valid`, `rd_count` all 0 throughout; first `fifo_rd_en` appears the cycle after reset falls.
- Bench FIFO model preloaded with A1, B2, C3, D4, `m_ready = 1` → `fifo_rd_en` high 4 consecutive cycles; `m_valid` high 4 consecutive cycles starting 2 cycles after the first read; data A1, B2, C3, D4; `rd_count = 4`.
- Same 4 words, `m_ready = 0` for 10 cycles → exactly 3 reads issued; `m_data = A1` held stable. Then `m_ready = 1` → A1, B2, C3, D4 delivered in order; total 4 reads.
- `fifo_empty = 1` throughout with `enable = 1` → `fifo_rd_en` never asserted, `m_valid` stays 0. Empty asserting mid-stream after 2 words → exactly 2 delivered.
- `enable` dropped in the cycle after the first read → that word is still delivered (`m_valid` 2 cycles after the read); no further `fifo_rd_en`. Re-enable → reading resumes with B2.
- 300 sequential words with random `m_ready` → in-order delivery across repeated buffer wrap; `rd_count = 300`. A reset pulse with `occ = 3` → `m_valid = 0` and `rd_count = 0` in the cycle after reset.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: issues FIFO reads against a 3-entry credit window and
// presents the returned words as a valid/ready stream at full throughput.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    logic [DATA_WIDTH-1:0] buf_q [0:2];
    logic [1:0]            wptr_q;
    logic [1:0]            rptr_q;
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  inflight_q;
    logic [CNT_WIDTH-1:0]  rd_count_q;
    logic                  has_credit;
    logic                  capture;
    logic                  pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read in flight already owns a buffer slot, so it counts against the credit.
    assign has_credit = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3;
    assign fifo_rd_en = enable && !fifo_empty && has_credit && !reset;

    assign capture  = inflight_q;
    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = buf_q[rptr_q];
    assign pop      = m_valid && m_ready;
    assign rd_count = rd_count_q;

    always_comb begin
        occ_d = occ_q;
        unique case ({capture, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
            wptr_q     <= 2'd0;
            rptr_q     <= 2'd0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            rd_count_q <= '0;
        end else begin
            inflight_q <= fifo_rd_en;
            occ_q      <= occ_d;
            if (capture) begin
                buf_q[wptr_q] <= fifo_dout;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q     <= ptr_inc(rptr_q);
                rd_count_q <= rd_count_q + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a registered-read FIFO model and a
// scoreboard queue checked by a forked stream monitor.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        fifo_empty;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [15:0] rd_count;

    logic [7:0]  fmem [0:1023];
    int          wr_idx = 0;
    int          rd_idx = 0;
    logic        force_empty = 1'b0;

    logic [7:0]  exp_q [$];
    logic [7:0]  mon_e;
    logic        flush_arm;
    int          rd_pulses;
    int          n_checks;
    int          n_fail;

    fifo_stream_reader #(
        .DATA_WIDTH(8),
        .CNT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .rd_count  (rd_count)
    );

    initial forever #5 clk = ~clk;

    // FIFO model with one-cycle registered read latency
    assign fifo_empty = force_empty || (rd_idx == wr_idx);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= fmem[rd_idx];
            rd_idx    <= rd_idx + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic fifo_push(input logic [7:0] w);
        fmem[wr_idx] = w;
        wr_idx++;
    endtask

    task automatic push_both(input logic [7:0] w);
        fifo_push(w);
        exp_q.push_back(w);
    endtask

    initial begin
        logic [7:0] rd_trace;
        logic [7:0] v_trace;
        logic       seen_rd;
        logic       seen_v;
        int         r0;
        int         guard;

        n_checks  = 0;
        n_fail    = 0;
        rd_pulses = 0;
        flush_arm = 1'b0;
        reset     = 1'b1;
        enable    = 1'b1;
        m_ready   = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (fifo_rd_en) rd_pulses++;
                if (fifo_rd_en && fifo_empty) check("read_on_empty", 1, 0);
                if (reset) begin
                    if (flush_arm) begin
                        exp_q.delete();
                        flush_arm = 1'b0;
                    end
                end else if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", {24'h0, m_data}, 32'hFFFF_FFFF);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("stream_data", {24'h0, m_data}, {24'h0, mon_e});
                    end
                end
            end
        join_none

        // Reset held with a non-empty FIFO
        push_both(8'hA1);
        push_both(8'hB2);
        push_both(8'hC3);
        push_both(8'hD4);
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_rd_en", {31'h0, fifo_rd_en}, 0);
            check("reset_m_valid", {31'h0, m_valid}, 0);
            check("reset_rd_count", {16'h0, rd_count}, 0);
            check("reset_m_data", {24'h0, m_data}, 0);
            cyc();
        end
        reset = 1'b0;

        // Full-throughput burst
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_trace[i] = fifo_rd_en;
            v_trace[i]  = m_valid;
        end
        check("burst_rd_en_pattern", {24'h0, rd_trace}, 32'h0F);
        check("burst_valid_pattern", {24'h0, v_trace}, 32'h3C);
        cyc();
        check("burst_rd_count", {16'h0, rd_count}, 4);
        check("burst_sb_empty", exp_q.size(), 0);

        // Backpressure: only three credits
        m_ready = 1'b0;
        r0 = rd_pulses;
        push_both(8'hA1);
        push_both(8'hB2);
        push_both(8'hC3);
        push_both(8'hD4);
        seen_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) begin
                seen_v = 1'b1;
                check("bp_head_stable", {24'h0, m_data}, 32'hA1);
            end
            cyc();
        end
        check("bp_reads", rd_pulses - r0, 3);
        check("bp_valid_seen", {31'h0, seen_v}, 1);
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_no_read_while_full", {31'h0, fifo_rd_en}, 0);
        cyc();
        @(negedge clk);
        check("bp_read_after_pop", {31'h0, fifo_rd_en}, 1);
        run(10);
        check("bp_total_reads", rd_pulses - r0, 4);
        check("bp_rd_count", {16'h0, rd_count}, 8);
        check("bp_sb_empty", exp_q.size(), 0);

        // Empty FIFO: nothing issued
        seen_rd = 1'b0;
        seen_v  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen_rd |= fifo_rd_en;
            seen_v  |= m_valid;
            cyc();
        end
        check("empty_no_read", {31'h0, seen_rd}, 0);
        check("empty_no_valid", {31'h0, seen_v}, 0);

        // Empty asserts after two reads
        r0 = rd_pulses;
        push_both(8'hA1);
        push_both(8'hB2);
        fifo_push(8'hC3);
        fifo_push(8'hD4);
        cyc();
        cyc();
        force_empty = 1'b1;
        run(8);
        check("mid_empty_reads", rd_pulses - r0, 2);
        check("mid_empty_rd_count", {16'h0, rd_count}, 10);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'hD4);
        force_empty = 1'b0;
        run(8);
        check("mid_resume_rd_count", {16'h0, rd_count}, 12);

        // Enable dropped after the first read
        r0 = rd_pulses;
        push_both(8'hA1);
        push_both(8'hB2);
        push_both(8'hC3);
        push_both(8'hD4);
        @(negedge clk);
        check("en_first_read", {31'h0, fifo_rd_en}, 1);
        cyc();
        enable = 1'b0;
        @(negedge clk);
        check("en_valid_n1", {31'h0, m_valid}, 0);
        cyc();
        @(negedge clk);
        check("en_valid_n2", {31'h0, m_valid}, 1);
        check("en_data_n2", {24'h0, m_data}, 32'hA1);
        run(8);
        check("en_off_reads", rd_pulses - r0, 1);
        check("en_off_rd_count", {16'h0, rd_count}, 13);
        enable = 1'b1;
        run(10);
        check("en_resume_reads", rd_pulses - r0, 4);
        check("en_resume_rd_count", {16'h0, rd_count}, 16);

        // Counter reset before the long run
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("pulse_rd_count", {16'h0, rd_count}, 0);

        // 300 words under random backpressure
        for (int i = 0; i < 300; i++) begin
            push_both(8'(i * 7 + 3));
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            m_ready = 1'($urandom_range(0, 1));
            cyc();
            guard++;
        end
        check("long_drain_timeout", exp_q.size(), 0);
        m_ready = 1'b1;
        run(2);
        check("long_rd_count", {16'h0, rd_count}, 300);

        // Reset with the buffer full
        m_ready = 1'b0;
        r0 = rd_pulses;
        push_both(8'h11);
        push_both(8'h22);
        push_both(8'h33);
        run(6);
        check("full_reads", rd_pulses - r0, 3);
        check("full_valid", {31'h0, m_valid}, 1);
        flush_arm = 1'b1;
        reset     = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_valid", {31'h0, m_valid}, 0);
        check("post_reset_rd_count", {16'h0, rd_count}, 0);
        check("post_reset_data", {24'h0, m_data}, 0);
        m_ready = 1'b1;
        seen_v  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clk);
            seen_v |= m_valid;
        end
        check("post_reset_no_valid", {31'h0, seen_v}, 0);
        check("post_reset_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
